// File: rtl/cnn16_pkg.sv
// Shared encodings for the CNN16 control unit and datapath: opcodes, bus
// sources, ALU operations, controller states and decoded instruction classes.
package cnn16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_DEC  = 3'd3,
        ST_EX0  = 3'd4,
        ST_EX1  = 3'd5,
        ST_HALT = 3'd6
    } state_e;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_LDV = 4'h5;
    localparam logic [3:0] OP_LDK = 4'h6;
    localparam logic [3:0] OP_LDG = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [4:0] BUS_NONE = 5'b00000;
    localparam logic [4:0] BUS_AC   = 5'b00001;
    localparam logic [4:0] BUS_PC   = 5'b00011;
    localparam logic [4:0] BUS_MEM  = 5'b00100;
    localparam logic [4:0] BUS_IR   = 5'b01110;

    localparam logic [3:0] ALU_PASS_B = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0001;
    localparam logic [3:0] ALU_MUL    = 4'b0010;

    // Instruction classes share one execute sequence per class
    typedef enum logic [2:0] {
        IC_MEM_ALU  = 3'd0,
        IC_STORE    = 3'd1,
        IC_JUMP     = 3'd2,
        IC_REG_LOAD = 3'd3,
        IC_OUT      = 3'd4,
        IC_HALT     = 3'd5,
        IC_ILLEGAL  = 3'd6
    } iclass_e;

    // reg_onehot is ordered {VREG, KREG, GREG}
    typedef struct packed {
        iclass_e    iclass;
        logic [3:0] alu_sel;
        logic [2:0] reg_onehot;
    } decode_t;

endpackage

// File: rtl/cnn16_decoder.sv
// Combinational opcode decoder: maps IR[15:12] to an instruction class plus
// the ALU operation and the target register for the load-to-register group.
module cnn16_decoder
    import cnn16_pkg::*;
(
    input  logic [3:0] opcode,
    output decode_t    dec
);

    always_comb begin
        dec.iclass     = IC_ILLEGAL;
        dec.alu_sel    = ALU_PASS_B;
        dec.reg_onehot = 3'b000;
        case (opcode)
            OP_LDA: dec.iclass = IC_MEM_ALU;
            OP_ADD: begin
                dec.iclass  = IC_MEM_ALU;
                dec.alu_sel = ALU_ADD;
            end
            OP_MUL: begin
                dec.iclass  = IC_MEM_ALU;
                dec.alu_sel = ALU_MUL;
            end
            OP_STA: dec.iclass = IC_STORE;
            OP_JMP: dec.iclass = IC_JUMP;
            OP_LDV: begin
                dec.iclass     = IC_REG_LOAD;
                dec.reg_onehot = 3'b100;
            end
            OP_LDK: begin
                dec.iclass     = IC_REG_LOAD;
                dec.reg_onehot = 3'b010;
            end
            OP_LDG: begin
                dec.iclass     = IC_REG_LOAD;
                dec.reg_onehot = 3'b001;
            end
            OP_OUT: dec.iclass = IC_OUT;
            OP_HLT: dec.iclass = IC_HALT;
            default: dec.iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cnn16_control_unit.sv
// CNN16 control unit: fetch/decode/execute sequencer. All strobes are decoded
// combinationally from the state register, the IR opcode and mem_ready.
module cnn16_control_unit
    import cnn16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] IR_Value,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        AC_Load,
    output logic        DR_Load,
    output logic        IR_Load,
    output logic        VREG_Load,
    output logic        KREG_Load,
    output logic        GREG_Load,
    output logic        OUTR_Load,
    output logic        PC_Load,
    output logic        AR_Load,
    output logic        PC_Inc,
    output logic [3:0]  alu_sel,
    output logic [4:0]  bus_sel,
    output logic        halted,
    output logic        illegal
);

    state_e  state_q, state_d;
    decode_t dec;
    logic    ir_addr_unused;

    // The address field reaches AR over the bus, never through this block
    assign ir_addr_unused = ^IR_Value[11:0];

    cnn16_decoder u_decoder (
        .opcode (IR_Value[15:12]),
        .dec    (dec)
    );

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AC_Load   = 1'b0;
        DR_Load   = 1'b0;
        IR_Load   = 1'b0;
        VREG_Load = 1'b0;
        KREG_Load = 1'b0;
        GREG_Load = 1'b0;
        OUTR_Load = 1'b0;
        PC_Load   = 1'b0;
        AR_Load   = 1'b0;
        PC_Inc    = 1'b0;
        alu_sel   = ALU_PASS_B;
        bus_sel   = BUS_NONE;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_F0;
            end
            ST_F0: begin
                bus_sel = BUS_PC;
                AR_Load = 1'b1;
                state_d = ST_F1;
            end
            ST_F1: begin
                mem_req = 1'b1;
                bus_sel = BUS_MEM;
                IR_Load = mem_ready;
                PC_Inc  = mem_ready;
                if (mem_ready) state_d = ST_DEC;
            end
            ST_DEC: begin
                bus_sel = BUS_IR;
                AR_Load = 1'b1;
                state_d = ST_EX0;
            end
            ST_EX0: begin
                case (dec.iclass)
                    IC_MEM_ALU: begin
                        mem_req = 1'b1;
                        bus_sel = BUS_MEM;
                        DR_Load = mem_ready;
                        if (mem_ready) state_d = ST_EX1;
                    end
                    IC_STORE: begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                        bus_sel = BUS_AC;
                        if (mem_ready) state_d = ST_F0;
                    end
                    IC_JUMP: begin
                        bus_sel = BUS_IR;
                        PC_Load = 1'b1;
                        state_d = ST_F0;
                    end
                    IC_REG_LOAD: begin
                        mem_req = 1'b1;
                        bus_sel = BUS_MEM;
                        {VREG_Load, KREG_Load, GREG_Load} = dec.reg_onehot & {3{mem_ready}};
                        if (mem_ready) state_d = ST_F0;
                    end
                    IC_OUT: begin
                        bus_sel   = BUS_AC;
                        OUTR_Load = 1'b1;
                        state_d   = ST_F0;
                    end
                    IC_HALT: state_d = ST_HALT;
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_F0;
                    end
                endcase
            end
            ST_EX1: begin
                AC_Load = 1'b1;
                alu_sel = dec.alu_sel;
                state_d = ST_F0;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

endmodule

// File: tb/tb_cnn16_control_unit.sv
// Bench for cnn16_control_unit: cycle-by-cycle vector table with the opcode and
// mem_ready driven directly, then program runs against a small datapath/memory model.
module tb_cnn16_control_unit;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_AC   = 5'b00001;
    localparam logic [4:0] B_PC   = 5'b00011;
    localparam logic [4:0] B_MEM  = 5'b00100;
    localparam logic [4:0] B_IR   = 5'b01110;
    localparam logic [3:0] A_PASS = 4'b0000;
    localparam logic [3:0] A_ADD  = 4'b0001;
    localparam logic [3:0] A_MUL  = 4'b0010;
    // Load strobe bits ordered {AC, DR, IR, VREG, KREG, GREG, OUTR, PC, AR}
    localparam logic [8:0] L_NONE = 9'h000;
    localparam logic [8:0] L_AC   = 9'h100;
    localparam logic [8:0] L_DR   = 9'h080;
    localparam logic [8:0] L_IR   = 9'h040;
    localparam logic [8:0] L_V    = 9'h020;
    localparam logic [8:0] L_K    = 9'h010;
    localparam logic [8:0] L_G    = 9'h008;
    localparam logic [8:0] L_OUT  = 9'h004;
    localparam logic [8:0] L_PC   = 9'h002;
    localparam logic [8:0] L_AR   = 9'h001;

    logic        clk = 1'b0;
    logic        rst, start, mem_ready;
    logic [15:0] IR_Value;
    logic        mem_req, mem_we, AC_Load, DR_Load, IR_Load, VREG_Load, KREG_Load;
    logic        GREG_Load, OUTR_Load, PC_Load, AR_Load, PC_Inc, halted, illegal;
    logic [3:0]  alu_sel;
    logic [4:0]  bus_sel;

    logic        direct_mode, mr_direct;
    logic [15:0] ir_direct;
    int          ready_delay;
    logic        host_we, host_clear;
    logic [11:0] host_addr;
    logic [15:0] host_data;

    logic [15:0] mem [0:4095];
    logic [15:0] ac, dr, ir_m, bus;
    logic [11:0] pc, ar;
    int          wait_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cnn16_control_unit dut (
        .clk (clk), .rst (rst), .start (start), .IR_Value (IR_Value), .mem_ready (mem_ready),
        .mem_req (mem_req), .mem_we (mem_we), .AC_Load (AC_Load), .DR_Load (DR_Load),
        .IR_Load (IR_Load), .VREG_Load (VREG_Load), .KREG_Load (KREG_Load),
        .GREG_Load (GREG_Load), .OUTR_Load (OUTR_Load), .PC_Load (PC_Load),
        .AR_Load (AR_Load), .PC_Inc (PC_Inc), .alu_sel (alu_sel), .bus_sel (bus_sel),
        .halted (halted), .illegal (illegal)
    );

    assign IR_Value  = direct_mode ? ir_direct : ir_m;
    assign mem_ready = direct_mode ? mr_direct : (wait_cnt >= ready_delay);

    // Datapath and memory model steered only by the DUT strobes
    always_comb begin
        bus = 16'h0000;
        case (bus_sel)
            B_PC:    bus = {4'h0, pc};
            B_MEM:   bus = mem[ar];
            B_AC:    bus = ac;
            B_IR:    bus = ir_m;
            default: bus = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (host_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'hF000;
        end else if (host_we) begin
            mem[host_addr] <= host_data;
        end else if (!rst && mem_req && mem_we && mem_ready) begin
            mem[ar] <= ac;
        end
        if (rst) begin
            ac <= '0; dr <= '0; ir_m <= '0; pc <= '0; ar <= '0; wait_cnt <= 0;
        end else begin
            if (AR_Load) ar <= bus[11:0];
            if (IR_Load) ir_m <= bus;
            if (DR_Load) dr <= bus;
            if (PC_Load) pc <= bus[11:0];
            else if (PC_Inc) pc <= pc + 12'd1;
            if (AC_Load) begin
                case (alu_sel)
                    A_ADD:   ac <= ac + dr;
                    A_MUL:   ac <= 16'(ac * dr);
                    default: ac <= dr;
                endcase
            end
            if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
            else                       wait_cnt <= 0;
        end
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] ir;
        logic        mr;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [15:0] ir,
                                input logic mr, input logic req, input logic we,
                                input logic [8:0] ld, input logic inc, input logic [3:0] alu,
                                input logic [4:0] bs, input logic h, input logic il);
        vec_t v;
        v.rst = r; v.start = s; v.ir = ir; v.mr = mr;
        v.exp = {req, we, ld, inc, alu, bs, h, il};
        return v;
    endfunction

    function automatic logic [22:0] outputs_now();
        return {mem_req, mem_we, AC_Load, DR_Load, IR_Load, VREG_Load, KREG_Load, GREG_Load,
                OUTR_Load, PC_Load, AR_Load, PC_Inc, alu_sel, bus_sel, halted, illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_vector(input int idx, input vec_t v);
        rst = v.rst; start = v.start; ir_direct = v.ir; mr_direct = v.mr;
        #1;
        check($sformatf("vec%0d", idx), 32'(outputs_now()), 32'(v.exp));
        @(negedge clk);
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    // Holds reset while memory is reprogrammed; leaves the DUT in IDLE at a negedge
    task automatic begin_program(input int delay);
        rst = 1'b1; start = 1'b0; ready_delay = delay;
        host_clear = 1'b1;
        @(negedge clk);
        host_clear = 1'b0;
    endtask

    task automatic end_program();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int runs[$];
    int wr_cycles, ill_cycles, ill_busy;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    task automatic run_until_halt(input string name, input int max_cycles);
        int cycles = 0;
        int req_run = 0;
        runs.delete(); wr_cycles = 0; ill_cycles = 0; ill_busy = 0;
        wr_addr = '0; wr_data = '0;
        while (!halted && cycles < max_cycles) begin
            if (mem_req) req_run++;
            else if (req_run > 0) begin
                runs.push_back(req_run);
                req_run = 0;
            end
            if (mem_req && mem_we) begin
                wr_cycles++; wr_addr = ar; wr_data = ac;
            end
            if (illegal) begin
                ill_cycles++;
                if (outputs_now() != 23'h000001) ill_busy++;
            end
            @(negedge clk);
            cycles++;
        end
        check({name, "_halt_reached"}, 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        direct_mode = 1'b1; mr_direct = 1'b0; ir_direct = '0; ready_delay = 0;
        host_we = 1'b0; host_clear = 1'b0; host_addr = '0; host_data = '0;
        rst = 1'b1; start = 1'b0;

        //                    r s ir       mr req we ld          inc alu     bus    h il
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 0, L_NONE,     0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 0, 1, 0, L_NONE,     0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 1, 1, 0, L_DR,       0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 0, 0, 0, L_AC,       0, A_MUL,  B_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h2005, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h1004, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h1004, 1, 1, 0, L_DR,       0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h1004, 1, 0, 0, L_AC,       0, A_ADD,  B_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 16'h1004, 0, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h1004, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h6010, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h6010, 0, 1, 0, L_NONE,     0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h6010, 1, 1, 0, L_K,        0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h6010, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h6010, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h7123, 0, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h7123, 1, 1, 0, L_G,        0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h7123, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h7123, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h5001, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h5001, 1, 1, 0, L_V,        0, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h5001, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h5001, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 1, 0, 0, L_OUT,      0, A_PASS, B_AC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h3020, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h3020, 0, 1, 1, L_NONE,     0, A_PASS, B_AC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h3020, 1, 1, 1, L_NONE,     0, A_PASS, B_AC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h3020, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h3020, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'h4100, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h4100, 0, 0, 0, L_PC,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'h4100, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'h4100, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'hC000, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'hC000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 1));
        vecs.push_back(mk(0, 0, 16'hC000, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));
        vecs.push_back(mk(0, 0, 16'hC000, 1, 1, 0, L_IR,       1, A_PASS, B_MEM,  0, 0));
        vecs.push_back(mk(0, 0, 16'hF000, 1, 0, 0, L_AR,       0, A_PASS, B_IR,   0, 0));
        vecs.push_back(mk(0, 0, 16'hF000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 1, 16'hF000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 1, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 1, 0));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(1, 1, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 1, 0, 0, L_NONE,     0, A_PASS, B_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, L_AR,       0, A_PASS, B_PC,   0, 0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) apply_vector(i, vecs[i]);

        direct_mode = 1'b0;

        // LDA 5 with mem_ready tied high: AC lands on the 5th edge after IDLE
        begin_program(0);
        poke(12'h000, 16'h0005);
        poke(12'h005, 16'h0007);
        end_program();
        kick();
        repeat (4) @(negedge clk);
        check("lda_ac_before_ex1", 32'(ac), 32'h0000);
        @(negedge clk);
        check("lda_ac", 32'(ac), 32'h0007);
        check("lda_pc", 32'(pc), 32'h001);

        // LDA/ADD with 3 wait cycles on every access
        begin_program(3);
        poke(12'h000, 16'h0010);
        poke(12'h001, 16'h1011);
        poke(12'h010, 16'h0003);
        poke(12'h011, 16'h0004);
        end_program();
        kick();
        run_until_halt("add", 200);
        check("add_ac", 32'(ac), 32'h0007);
        check("add_access_count", 32'(runs.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("add_req_run%0d", i), 32'(runs.size() > i ? runs[i] : 0), 32'd4);

        // STA 0x020 after loading AC with 0x1234
        begin_program(0);
        poke(12'h000, 16'h0030);
        poke(12'h001, 16'h3020);
        poke(12'h030, 16'h1234);
        end_program();
        kick();
        run_until_halt("sta", 200);
        check("sta_write_cycles", 32'(wr_cycles), 32'd1);
        check("sta_addr", 32'(wr_addr), 32'h020);
        check("sta_data", 32'(wr_data), 32'h1234);
        check("sta_mem", 32'(mem[12'h020]), 32'h1234);

        // JMP 0x100 into HLT; start pulses must not wake the halted core
        begin_program(0);
        poke(12'h000, 16'h4100);
        end_program();
        kick();
        repeat (4) @(negedge clk);
        check("jmp_pc", 32'(pc), 32'h100);
        run_until_halt("jmp", 200);
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            @(negedge clk);
            check($sformatf("halt_hold%0d", i), 32'(outputs_now()), 32'h000002);
        end
        start = 1'b0;

        // Undefined opcode 0xA followed by HLT
        begin_program(0);
        poke(12'h000, 16'hA000);
        end_program();
        kick();
        run_until_halt("illegal", 200);
        check("illegal_cycles", 32'(ill_cycles), 32'd1);
        check("illegal_quiet", 32'(ill_busy), 32'd0);
        check("illegal_pc", 32'(pc), 32'h002);

        // Reset during a stalled instruction fetch
        begin_program(1000);
        end_program();
        kick();
        repeat (2) @(negedge clk);
        check("f1_wait_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_f1_outputs", 32'(outputs_now()), 32'h000000);
        check("rst_f1_pc", 32'(pc), 32'h000);
        @(negedge clk);
        check("rst_f1_idle", 32'(outputs_now()), 32'h000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
